// File: rtl/uart_rx.sv
// uart_rx: UART receiver for the 8N1-style link driven by uart_tx.
//
// The asynchronous uart_rxd pin is passed through a two-flop synchroniser. A falling
// edge on the synchronised line starts a frame, and each bit is sampled near its middle.
// The payload is shifted in LSB-first. A new byte is announced with a one-cycle valid
// strobe.
//
// Optional feature (compile-time macro UART_RX_FERR_EN):
//   defined   - a uart_rx_ferr port is added; a frame whose stop bit samples low pulses
//               ferr instead of valid and leaves uart_rx_data untouched.
//   undefined - there is no ferr port; the stop bit is ignored and every frame is delivered.
//
// Ports:
//   clk            in   system clock, all logic on posedge
//   resetn         in   synchronous, active-low reset
//   uart_rxd       in   asynchronous serial input, idle high
//   uart_rx_en     in   receive enable, looked at only while idle
//   uart_rx_busy   out  high while a frame is in progress
//   uart_rx_valid  out  one-cycle strobe: uart_rx_data holds a new frame
//   uart_rx_data   out  last received payload, held until the next valid
//   uart_rx_ferr   out  framing-error strobe (UART_RX_FERR_EN only)

module uart_rx #(
    parameter int unsigned BIT_RATE     = 9600,
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic                    uart_rx_busy,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data
`ifdef UART_RX_FERR_EN
    ,
    output logic                    uart_rx_ferr
`endif
);

    localparam int unsigned CYCLES_PER_BIT = (1_000_000_000 / BIT_RATE) /
                                             (1_000_000_000 / CLK_HZ);
    localparam int unsigned HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int unsigned COUNT_W        = 1 + $clog2(CYCLES_PER_BIT);
    localparam int unsigned BIT_W          = $clog2(PAYLOAD_BITS + 1);

    // Without stop bits the frame ends at its last data sample.
    localparam int unsigned STOP_SAMPLE    = (STOP_BITS == 0) ? 0 : CYCLES_PER_BIT - 1;

    localparam logic [COUNT_W-1:0] HALF_CNT = COUNT_W'(HALF_BIT);
    localparam logic [COUNT_W-1:0] LAST_CNT = COUNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [COUNT_W-1:0] EMIT_CNT = COUNT_W'(STOP_SAMPLE + 1);
`ifdef UART_RX_FERR_EN
    localparam logic [COUNT_W-1:0] STOP_CNT = COUNT_W'(STOP_SAMPLE);
`endif
    localparam logic [BIT_W-1:0]   LAST_BIT = BIT_W'(PAYLOAD_BITS - 1);
    localparam logic [BIT_W-1:0]   FULL_BIT = BIT_W'(PAYLOAD_BITS);

    typedef enum logic [1:0] {StIdle, StStart, StRecv, StStop} state_e;

    state_e                  state_q;
    logic                    rxd_meta_q;
    logic                    rxd_sync_q;
    logic                    rxd_prev_q;
    logic [COUNT_W-1:0]      cycle_cnt_q;
    logic [BIT_W-1:0]        bit_cnt_q;
    logic [PAYLOAD_BITS-1:0] shift_q;
`ifdef UART_RX_FERR_EN
    logic                    stop_bit_q;
`endif

    logic rxd_fall;

    // A line held low never looks like a new start bit; only a 1 -> 0 transition does.
    assign rxd_fall = rxd_prev_q & ~rxd_sync_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= StIdle;
            rxd_meta_q    <= 1'b1;
            rxd_sync_q    <= 1'b1;
            rxd_prev_q    <= 1'b1;
            cycle_cnt_q   <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            uart_rx_busy  <= 1'b0;
            uart_rx_valid <= 1'b0;
            uart_rx_data  <= '0;
`ifdef UART_RX_FERR_EN
            stop_bit_q    <= 1'b0;
            uart_rx_ferr  <= 1'b0;
`endif
        end else begin
            rxd_meta_q    <= uart_rxd;
            rxd_sync_q    <= rxd_meta_q;
            rxd_prev_q    <= rxd_sync_q;
            uart_rx_valid <= 1'b0;
`ifdef UART_RX_FERR_EN
            uart_rx_ferr  <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (rxd_fall && uart_rx_en) begin
                        state_q      <= StStart;
                        cycle_cnt_q  <= '0;
                        bit_cnt_q    <= '0;
                        uart_rx_busy <= 1'b1;
                    end
                end

                StStart: begin
                    if (cycle_cnt_q == HALF_CNT) begin
                        cycle_cnt_q <= '0;
                        if (!rxd_sync_q) begin
                            state_q <= StRecv;
                        end else begin
                            // Line is back high mid-start-bit: treat as a glitch.
                            state_q      <= StIdle;
                            uart_rx_busy <= 1'b0;
                        end
                    end else begin
                        cycle_cnt_q <= cycle_cnt_q + COUNT_W'(1);
                    end
                end

                StRecv: begin
                    if (cycle_cnt_q == LAST_CNT) begin
                        cycle_cnt_q <= '0;
                        shift_q     <= {rxd_sync_q, shift_q[PAYLOAD_BITS-1:1]};
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= StStop;
                        end
                        if (bit_cnt_q != FULL_BIT) begin
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        end
                    end else begin
                        cycle_cnt_q <= cycle_cnt_q + COUNT_W'(1);
                    end
                end

                StStop: begin
                    // Sample mid-stop-bit, deliver one cycle later and go idle so a
                    // back-to-back start edge is still caught.
                    if (cycle_cnt_q == EMIT_CNT) begin
                        state_q      <= StIdle;
                        cycle_cnt_q  <= '0;
                        uart_rx_busy <= 1'b0;
`ifdef UART_RX_FERR_EN
                        if (stop_bit_q) begin
                            uart_rx_valid <= 1'b1;
                            uart_rx_data  <= shift_q;
                        end else begin
                            uart_rx_ferr  <= 1'b1;
                        end
`else
                        uart_rx_valid <= 1'b1;
                        uart_rx_data  <= shift_q;
`endif
                    end else begin
`ifdef UART_RX_FERR_EN
                        if (cycle_cnt_q == STOP_CNT) begin
                            stop_bit_q <= rxd_sync_q;
                        end
`endif
                        cycle_cnt_q <= cycle_cnt_q + COUNT_W'(1);
                    end
                end

                default: begin
                    state_q      <= StIdle;
                    uart_rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
